// File: rtl/veripg_elastic_pipe_if.sv
// veripg_elastic_pipe_if: valid/ready payload channel used on both sides of the elastic pipe.
interface veripg_elastic_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic valid;
    logic ready;
    modport master (output data, valid, input ready);
    modport slave (input data, valid, output ready);
endinterface

// File: rtl/veripg_elastic_pipe.sv
// veripg_elastic_pipe: STAGES-deep valid/ready register pipeline with occupancy count.
// Define VERIPG_PIPE_FLUSH_EN to add a synchronous flush input that empties every stage.
module veripg_elastic_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES = 2,
    localparam int CNT_W = $clog2(STAGES + 1)
) (
    input logic clk,
    input logic rst_n,
    veripg_elastic_pipe_if.slave up,
    veripg_elastic_pipe_if.master dn,
`ifdef VERIPG_PIPE_FLUSH_EN
    input logic flush,
`endif
    output logic [CNT_W-1:0] count
);
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] src_v;
    logic [DATA_WIDTH-1:0] d [STAGES];
    logic [DATA_WIDTH-1:0] src_d [STAGES];
    logic [STAGES:0] rdy;
    logic fl;
    logic in_fire;
    logic out_fire;
`ifdef VERIPG_PIPE_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    // Each stage may move whenever it is empty or the stage after it moves.
    always_comb begin
        rdy[STAGES] = dn.ready;
        for (int i = STAGES - 1; i >= 0; i--) rdy[i] = !v[i] || rdy[i + 1];
    end
    always_comb begin
        src_v[0] = up.valid;
        src_d[0] = up.data;
        for (int i = 1; i < STAGES; i++) begin
            src_v[i] = v[i - 1];
            src_d[i] = d[i - 1];
        end
    end
    assign up.ready = rdy[0] && !fl;
    assign dn.valid = v[STAGES - 1];
    assign dn.data = d[STAGES - 1];
    assign in_fire = up.valid && up.ready;
    assign out_fire = dn.valid && dn.ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= '0;
            count <= '0;
        end else if (fl) begin
            v <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++)
                if (rdy[i]) begin
                    v[i] <= src_v[i];
                    if (src_v[i]) d[i] <= src_d[i];
                end
            count <= (in_fire && !out_fire) ? count + CNT_W'(1) :
                     (!in_fire && out_fire) ? count - CNT_W'(1) : count;
        end
    end
endmodule
